// File: rtl/senior_id_tracker_v2_pkg.sv
// Shared types for the senior ID tracker and the scoreboard that reuses it.
// Holds the default ID width, the ID type, error codes and the depth helper.
package senior_tracker_pkg;

    localparam int ID_W_DEF = 6;

    typedef logic [ID_W_DEF-1:0] id_t;

    // Bit 0 flags an illegal request, bit 1 a spurious response.
    typedef enum logic [1:0] {
        ERR_NONE = 2'b00,
        ERR_REQ  = 2'b01,
        ERR_RESP = 2'b10,
        ERR_BOTH = 2'b11
    } err_code_t;

    function automatic int unsigned depth_of(input int unsigned id_w);
        return 32'd1 << id_w;
    endfunction

endpackage

// File: rtl/senior_id_tracker_v2_if.sv
// Request/response bus and status outputs of the senior ID tracker.
// The issuer/bench uses master; the tracker uses slave.
interface senior_id_tracker_v2_if
    import senior_tracker_pkg::*;
#(
    parameter int ID_W = ID_W_DEF
);

    logic            req_valid;
    logic [ID_W-1:0] req_id;
    logic            resp_valid;
    logic [ID_W-1:0] resp_id;
    logic [ID_W-1:0] next_id;
    logic            senior_valid;
    logic [ID_W-1:0] most_senior_id;
    logic [ID_W:0]   outstanding;
    logic            full;
    logic            timeout;
    logic            err_req;
    logic            err_resp;

    modport master (
        output req_valid, req_id, resp_valid, resp_id,
        input  next_id, senior_valid, most_senior_id, outstanding,
        input  full, timeout, err_req, err_resp
    );

    modport slave (
        input  req_valid, req_id, resp_valid, resp_id,
        output next_id, senior_valid, most_senior_id, outstanding,
        output full, timeout, err_req, err_resp
    );

endinterface

// File: rtl/senior_id_tracker_v2_rot_prio_find.sv
// Rotating priority finder: first set bit of vec at or after start,
// wrapping modulo N. Purely combinational.
module rot_prio_find #(
    parameter int N = 8,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] vec,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = |vec;
        idx   = start;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[(int'(start) + i) % N]) begin
                idx = W'((int'(start) + i) % N);
            end
        end
    end

endmodule

// File: rtl/senior_id_tracker_v2.sv
// Tracks outstanding IDs in issue order and reports the oldest one,
// with an outstanding count, full flag, watchdog and protocol errors.
module senior_id_tracker_v2
    import senior_tracker_pkg::*;
#(
    parameter int ID_W    = ID_W_DEF,
    parameter int TIMEOUT = 1024
) (
    input logic                  clk,
    input logic                  reset,
    senior_id_tracker_v2_if.slave bus
);

    localparam int DEPTH = int'(depth_of(ID_W));
    localparam int AGE_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);
    localparam logic [ID_W:0] CNT_FULL = (ID_W + 1)'(DEPTH);

    logic [DEPTH-1:0] pending_q, pending_d;
    logic [ID_W-1:0]  next_q, next_d;
    logic [ID_W-1:0]  senior_q, senior_d;
    logic             valid_q, valid_d;
    logic [ID_W:0]    cnt_q, cnt_d;
    logic             full_q, full_d;
    logic [AGE_W-1:0] age_q, age_d;
    logic             tmo_q, tmo_d;
    err_code_t        err_q, err_d;

    logic             req_ok;
    logic             resp_ok;
    logic             found;
    logic [ID_W-1:0]  scan_idx;

    // Qualify request/response and update bitmap, pointer and count.
    always_comb begin
        req_ok    = bus.req_valid && (bus.req_id == next_q) && !full_q;
        resp_ok   = bus.resp_valid && pending_q[bus.resp_id];
        pending_d = pending_q;
        if (resp_ok) pending_d[bus.resp_id] = 1'b0;
        if (req_ok)  pending_d[bus.req_id]  = 1'b1;
        next_d = req_ok ? next_q + 1'b1 : next_q;
        cnt_d  = cnt_q;
        if (req_ok && !resp_ok) cnt_d = cnt_q + 1'b1;
        if (!req_ok && resp_ok) cnt_d = cnt_q - 1'b1;
        full_d = (cnt_d == CNT_FULL);
        err_d  = err_code_t'({bus.resp_valid && !resp_ok,
                              bus.req_valid && !req_ok});
    end

    // Scanning from the current senior keeps issue order across wrap.
    rot_prio_find #(.N(DEPTH)) u_scan (
        .vec   (pending_d),
        .start (senior_q),
        .found (found),
        .idx   (scan_idx)
    );

    // Pick the next senior and age it; a new or absent senior restarts age.
    always_comb begin
        valid_d  = found;
        senior_d = found ? scan_idx : senior_q;
        age_d    = age_q;
        if (!valid_d || !valid_q || (senior_d != senior_q)) begin
            age_d = '0;
        end else if (age_q != AGE_MAX) begin
            age_d = age_q + 1'b1;
        end
        tmo_d = (TIMEOUT != 0) && (age_d == AGE_MAX) && (age_q != AGE_MAX);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_q <= '0;
            next_q    <= '0;
            senior_q  <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
            full_q    <= 1'b0;
            age_q     <= '0;
            tmo_q     <= 1'b0;
            err_q     <= ERR_NONE;
        end else begin
            pending_q <= pending_d;
            next_q    <= next_d;
            senior_q  <= senior_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
            full_q    <= full_d;
            age_q     <= age_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
        end
    end

    assign bus.next_id        = next_q;
    assign bus.senior_valid   = valid_q;
    assign bus.most_senior_id = senior_q;
    assign bus.outstanding    = cnt_q;
    assign bus.full           = full_q;
    assign bus.timeout        = tmo_q;
    assign bus.err_req        = err_q[0];
    assign bus.err_resp       = err_q[1];

endmodule

// File: tb/tb_senior_id_tracker_v2.sv
// Directed bench for senior_id_tracker_v2 with ID_W=3, TIMEOUT=4.
// Vector table for ordering/count/error cases, then reset and watchdog sequences.
module tb_senior_id_tracker_v2;

    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    int   pulses = 0;

    always #5 clk = ~clk;

    senior_id_tracker_v2_if #(.ID_W(3)) bus ();

    senior_id_tracker_v2 #(.ID_W(3), .TIMEOUT(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        bit       rv;
        logic [2:0] rid;
        bit       sv;
        logic [2:0] sid;
        bit       e_sv;
        logic [2:0] e_ms;
        logic [3:0] e_out;
        bit       e_full;
        logic [2:0] e_next;
        bit       e_er;
        bit       e_es;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rv, input int rid, input bit sv, input int sid,
                       input bit esv, input int ems, input int eout, input bit efull,
                       input int enext, input bit eer, input bit ees);
        vec_t v;
        v.rv = rv; v.rid = 3'(rid); v.sv = sv; v.sid = 3'(sid);
        v.e_sv = esv; v.e_ms = 3'(ems); v.e_out = 4'(eout); v.e_full = efull;
        v.e_next = 3'(enext); v.e_er = eer; v.e_es = ees;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input bit rv, input int rid, input bit sv, input int sid);
        bus.req_valid  = rv;
        bus.req_id     = 3'(rid);
        bus.resp_valid = sv;
        bus.resp_id    = 3'(sid);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string p, input bit esv, input int ems, input int eout,
                           input bit efull, input int enext, input bit eer, input bit ees);
        chk({p, "_senior_valid"}, 32'(bus.senior_valid), 32'(esv));
        chk({p, "_most_senior"}, 32'(bus.most_senior_id), 32'(ems));
        chk({p, "_outstanding"}, 32'(bus.outstanding), 32'(eout));
        chk({p, "_full"}, 32'(bus.full), 32'(efull));
        chk({p, "_next_id"}, 32'(bus.next_id), 32'(enext));
        chk({p, "_err_req"}, 32'(bus.err_req), 32'(eer));
        chk({p, "_err_resp"}, 32'(bus.err_resp), 32'(ees));
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        // Issue 0..7, respond out of order.
        for (int i = 0; i < 8; i++) add(1, i, 0, 0, 1, 0, i + 1, i == 7, (i + 1) % 8, 0, 0);
        add(0, 0, 1, 4, 1, 0, 7, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 1, 6, 0, 0, 0, 0);
        add(0, 0, 1, 1, 1, 2, 5, 0, 0, 0, 0);
        add(0, 0, 1, 3, 1, 2, 4, 0, 0, 0, 0);
        add(0, 0, 1, 5, 1, 2, 3, 0, 0, 0, 0);
        add(0, 0, 1, 6, 1, 2, 2, 0, 0, 0, 0);
        add(0, 0, 1, 2, 1, 7, 1, 0, 0, 0, 0);
        add(0, 0, 1, 7, 0, 7, 0, 0, 0, 0, 0);
        // Wrap ordering: older 6,7 precede reissued 0,1.
        for (int i = 0; i < 8; i++) add(1, i, 0, 0, 1, 0, i + 1, i == 7, (i + 1) % 8, 0, 0);
        for (int k = 0; k < 6; k++) add(0, 0, 1, k, 1, k + 1, 7 - k, 0, 0, 0, 0);
        add(1, 0, 0, 0, 1, 6, 3, 0, 1, 0, 0);
        add(1, 1, 0, 0, 1, 6, 4, 0, 2, 0, 0);
        add(0, 0, 1, 6, 1, 7, 3, 0, 2, 0, 0);
        add(0, 0, 1, 7, 1, 0, 2, 0, 2, 0, 0);
        add(0, 0, 1, 0, 1, 1, 1, 0, 2, 0, 0);
        add(0, 0, 1, 1, 0, 1, 0, 0, 2, 0, 0);
        // Fill from 2, then illegal requests while full and with wrong ID.
        for (int i = 0; i < 8; i++) add(1, (i + 2) % 8, 0, 0, 1, 2, i + 1, i == 7, (i + 3) % 8, 0, 0);
        add(1, 2, 0, 0, 1, 2, 8, 1, 2, 1, 0);
        add(1, 5, 0, 0, 1, 2, 8, 1, 2, 1, 0);
        add(0, 0, 0, 0, 1, 2, 8, 1, 2, 0, 0);
        add(0, 0, 1, 2, 1, 3, 7, 0, 2, 0, 0);
        add(1, 5, 0, 0, 1, 3, 7, 0, 2, 1, 0);
        add(1, 2, 0, 0, 1, 3, 8, 1, 3, 0, 0);
        add(0, 0, 1, 3, 1, 4, 7, 0, 3, 0, 0);
        add(1, 3, 1, 4, 1, 5, 7, 0, 4, 0, 0);

        drive(0, 0, 0, 0);
        reset = 1'b1;
        step();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
        chk("reset_timeout", 32'(bus.timeout), 32'd0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            drive(tbl[i].rv, int'(tbl[i].rid), tbl[i].sv, int'(tbl[i].sid));
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].e_sv, int'(tbl[i].e_ms),
                    int'(tbl[i].e_out), tbl[i].e_full, int'(tbl[i].e_next),
                    tbl[i].e_er, tbl[i].e_es);
        end

        // Asynchronous reset with 5 outstanding IDs.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, i, 0, 0);
            step();
        end
        drive(0, 0, 1, 0);
        step();
        chk_all("pre_arst", 1, 1, 5, 0, 6, 0, 0);
        drive(0, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        chk_all("arst", 0, 0, 0, 0, 0, 0, 0);
        chk("arst_timeout", 32'(bus.timeout), 32'd0);
        #1;
        reset = 1'b0;
        drive(1, 0, 0, 0);
        step();
        chk_all("post_arst_req0", 1, 0, 1, 0, 1, 0, 0);

        // Spurious responses, including same-cycle request of that ID.
        drive(0, 0, 1, 5);
        step();
        chk_all("spur5", 1, 0, 1, 0, 1, 0, 1);
        drive(0, 0, 0, 0);
        step();
        chk("spur5_clear", 32'(bus.err_resp), 32'd0);
        drive(1, 1, 0, 0);
        step();
        drive(1, 2, 0, 0);
        step();
        drive(1, 3, 1, 3);
        step();
        chk_all("spur3_req3", 1, 0, 4, 0, 4, 0, 1);
        drive(0, 0, 1, 3);
        step();
        chk_all("resp3_legal", 1, 0, 3, 0, 4, 0, 0);

        // Watchdog: one pulse 4 cycles after the senior appears.
        do_reset();
        drive(1, 0, 0, 0);
        step();
        chk("wd_valid", 32'(bus.senior_valid), 32'd1);
        chk("wd_t0", 32'(bus.timeout), 32'd0);
        drive(0, 0, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            step();
            if (bus.timeout === 1'b1) pulses++;
            chk($sformatf("wd_t%0d", k), 32'(bus.timeout), 32'(k == 4));
        end
        drive(0, 0, 1, 0);
        step();
        chk("wd_resp_valid", 32'(bus.senior_valid), 32'd0);
        chk("wd_resp_t", 32'(bus.timeout), 32'd0);
        drive(0, 0, 0, 0);
        for (int k = 0; k < 6; k++) begin
            step();
            if (bus.timeout === 1'b1) pulses++;
            chk($sformatf("wd_after%0d", k), 32'(bus.timeout), 32'd0);
        end
        chk("wd_pulses", 32'(pulses), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
